// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave fronting an 8x8 register file; 16-bit frames {cmd, data}, MISO returns regfile[addr] in byte 1.
// Define SPI_SLAVE_WRITE_EN to let cmd bit7 write the data byte; otherwise the file is read-only at its reset values.
module spi_slave_regfile #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       SCLK,
  input  logic       SS,
  input  logic       MOSI_bit,
  output logic       MISO_bit,
  output logic       frame_done,
  output logic       frame_err,
  output logic [2:0] last_addr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] RST_VAL [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};

`ifdef SPI_SLAVE_WRITE_EN
  localparam int SR_W = 7;
`else
  localparam int SR_W = 2;
`endif

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, ss_prev_q;
  logic [SYNC_STAGES:0]   warm_q, warm_d;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [SR_W-1:0] shift_q, shift_d;
  logic [2:0]      addr_q, addr_d;
  logic [7:0]      tx_q, tx_d;
  logic            miso_q, miso_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [2:0]      last_addr_q, last_addr_d;
  logic [7:0]      rf [8];

  logic       sclk_s, ss_s, mosi_s, live;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [2:0] cmd_addr;

`ifdef SPI_SLAVE_WRITE_EN
  logic       wr_q, wr_d;
  logic       we;
  logic [7:0] rf_q [8];
  logic [7:0] rf_d [8];
`endif

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI_bit};
    warm_d      = {warm_q[SYNC_STAGES-1:0], 1'b1};
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edges are ignored until real samples have reached both the sync output and the
  // prev flop, so an SS held low across reset cannot fake a falling edge off the preset.
  assign live      = warm_q[SYNC_STAGES];
  assign sclk_rise = live &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = live & ~sclk_s &  sclk_prev_q;
  assign ss_rise   = live &  ss_s   & ~ss_prev_q;
  assign ss_fall   = live & ~ss_s   &  ss_prev_q;

  assign cmd_addr = {shift_q[1:0], mosi_s};

`ifdef SPI_SLAVE_WRITE_EN
  assign rf = rf_q;
`else
  assign rf = RST_VAL;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    last_addr_d = last_addr_q;
`ifdef SPI_SLAVE_WRITE_EN
    wr_d        = wr_q;
    we          = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = CMD;
          cnt_d   = 4'd0;
          miso_d  = 1'b0;
        end
      end
      CMD: begin
        // SS rising wins over a coincident SCLK edge.
        if (ss_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          shift_d = {shift_q[SR_W-2:0], mosi_s};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = RESP;
            addr_d  = cmd_addr;
            tx_d    = rf[cmd_addr];
            miso_d  = 1'b0;
`ifdef SPI_SLAVE_WRITE_EN
            wr_d    = shift_q[6];
`endif
          end
        end
      end
      RESP: begin
        if (ss_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end else if (sclk_rise) begin
          shift_d = {shift_q[SR_W-2:0], mosi_s};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d     = DONE;
            done_d      = 1'b1;
            last_addr_d = addr_q;
            miso_d      = 1'b0;
`ifdef SPI_SLAVE_WRITE_EN
            we          = wr_q;
`endif
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_WRITE_EN
  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[addr_q] = {shift_q[6:0], mosi_s};
  end
`endif

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      warm_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= '0;
      addr_q      <= 3'd0;
      tx_q        <= 8'd0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_addr_q <= 3'd0;
`ifdef SPI_SLAVE_WRITE_EN
      wr_q        <= 1'b0;
      rf_q        <= RST_VAL;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      warm_q      <= warm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_addr_q <= last_addr_d;
`ifdef SPI_SLAVE_WRITE_EN
      wr_q        <= wr_d;
      rf_q        <= rf_d;
`endif
    end
  end

  assign MISO_bit   = miso_q & (state_q == RESP) & ~ss_s;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign last_addr  = last_addr_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: mode-0 master at 1 MHz SCLK against a 50 MHz core clock.
module tb_spi_slave_regfile;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       SCLK;
  logic       SS;
  logic       MOSI_bit;
  logic       MISO_bit;
  logic       frame_done;
  logic       frame_err;
  logic [2:0] last_addr;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

`ifdef SPI_SLAVE_WRITE_EN
  localparam logic [7:0] EXP_RD2 = 8'hA5;
`else
  localparam logic [7:0] EXP_RD2 = 8'h5B;
`endif

  spi_slave_regfile #(.SYNC_STAGES(2)) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .SCLK       (SCLK),
    .SS         (SS),
    .MOSI_bit   (MOSI_bit),
    .MISO_bit   (MISO_bit),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .last_addr  (last_addr)
  );

  always #10 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One SS window of nbits SCLK pulses; tx is right-aligned, sent MSB first.
  // rst_bit >= 0 pulses reset just before that bit and checks outputs while it is held.
  task automatic spi_frame(input logic [31:0] tx, input int nbits, input int rst_bit,
                           output logic [31:0] rx);
    rx = '0;
    SS = 1'b0;
    #500;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        reset = 1'b1;
        #60;
        check("rst_outputs", {28'd0, MISO_bit, frame_done, frame_err, last_addr == 3'd0 ? 1'b0 : 1'b1}, 32'd0);
        #40;
        reset = 1'b0;
      end
      MOSI_bit = tx[nbits-1-i];
      #500;
      SCLK = 1'b1;
      rx = {rx[30:0], MISO_bit};
      #500;
      SCLK = 1'b0;
    end
    #500;
    SS = 1'b1;
    #400;
  endtask

  logic [31:0] rx;
  int d0, e0;

  initial begin
    reset    = 1'b1;
    SCLK     = 1'b0;
    SS       = 1'b1;
    MOSI_bit = 1'b0;
    #105;
    check("reset_miso", {31'd0, MISO_bit}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    check("reset_last_addr", {29'd0, last_addr}, 32'd0);
    reset = 1'b0;
    #200;

    // Read addr 3.
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(32'h0300, 16, -1, rx);
    check("rd3_byte1", {24'd0, rx[7:0]}, 32'h4F);
    check("rd3_byte0", {24'd0, rx[15:8]}, 32'h00);
    check("rd3_done_pulses", done_cnt - d0, 32'd1);
    check("rd3_err_pulses", err_cnt - e0, 32'd0);
    check("rd3_last_addr", {29'd0, last_addr}, 32'd3);

    // Abort after 5 bits.
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(32'h0, 5, -1, rx);
    check("abort_err_pulses", err_cnt - e0, 32'd1);
    check("abort_done_pulses", done_cnt - d0, 32'd0);
    check("abort_last_addr", {29'd0, last_addr}, 32'd3);

    spi_frame(32'h0500, 16, -1, rx);
    check("rd5_byte1", {24'd0, rx[7:0]}, 32'h6D);
    check("rd5_last_addr", {29'd0, last_addr}, 32'd5);

    // Write 0xA5 to addr 2; frame itself returns the old contents.
    d0 = done_cnt;
    spi_frame(32'h82A5, 16, -1, rx);
    check("wr2_byte1_old", {24'd0, rx[7:0]}, 32'h5B);
    check("wr2_last_addr", {29'd0, last_addr}, 32'd2);
    check("wr2_done_pulses", done_cnt - d0, 32'd1);

    spi_frame(32'h0200, 16, -1, rx);
    check("rd2_after_wr", {24'd0, rx[7:0]}, {24'd0, EXP_RD2});

    // Reset at bit 10 of a write to addr 1.
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(32'h8111, 16, 10, rx);
    check("rstmid_done_pulses", done_cnt - d0, 32'd0);
    check("rstmid_err_pulses", err_cnt - e0, 32'd0);
    check("rstmid_last_addr", {29'd0, last_addr}, 32'd0);

    spi_frame(32'h0100, 16, -1, rx);
    check("rd1_byte1", {24'd0, rx[7:0]}, 32'h06);
    check("rd1_last_addr", {29'd0, last_addr}, 32'd1);

    // Overrun: 20 pulses reading addr 7.
    d0 = done_cnt;
    spi_frame(32'h07000, 20, -1, rx);
    check("ovr_byte0", {24'd0, rx[19:12]}, 32'h00);
    check("ovr_byte1", {24'd0, rx[11:4]}, 32'h07);
    check("ovr_trailing", {28'd0, rx[3:0]}, 32'h0);
    check("ovr_done_pulses", done_cnt - d0, 32'd1);
    check("ovr_last_addr", {29'd0, last_addr}, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
